palette_arbiter: RTL and testbench
==================================

Name: palette_arbiter

Overview:
- Time-multiplexes one single-port 768x5 palette RAM (synchronous read, 1-cycle latency) between the video colour lookup and CPU read/write accesses.
- Each pixel period gets three video reads (R, G, B) plus at least one CPU slot. During blanking, the CPU gets every slot.
- After reset, a sequencer clears the whole RAM before accepting CPU traffic.
- Sits between the CPU bus decode and the palette RAM. Drives the registered RGB outputs to the video DAC.

Parameters:
- PAL_DEPTH, 768, number of RAM entries (R 0-255, G 256-511, B 512-767).
- DW, 5, colour component width.
- IW, 8, colour index width.
- INIT_CLEAR, 1, when 1 run the clear sequence after reset; when 0 go straight to IDLE.

Ports:
- dclk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ce_pix  in  1  pixel enable; one pulse per pixel, period >= 4 dclk
- blank  in  1  blanking, sampled on ce_pix
- s  in  1  index select: 0 selects ca, 1 selects cb; sampled on ce_pix
- ca  in  8  layer A colour index
- cb  in  8  layer B colour index
- cpu_req  in  1  CPU access request (level); held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high
- cpu_addr  in  10  {ah,al,A[8:1]} word address; stable while cpu_req is high
- cpu_wdata  in  5  write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  5  read data, valid when cpu_ack is high
- ram_addr  out  10  RAM address
- ram_we  out  1  RAM write strobe
- ram_wdata  out  5  RAM write data
- ram_rdata  in  5  RAM read data, 1 cycle after ram_addr
- r_out  out  5  red output
- g_out  out  5  green output
- b_out  out  5  blue output
- init_busy  out  1  high while the clear sequence runs

Behaviour:
- Reset values:
  - All outputs 0, except init_busy = INIT_CLEAR.
  - State = INIT if INIT_CLEAR = 1, else IDLE.
  - slot = 3.
  - Reset asserted mid-operation aborts everything: no ack is issued and the clear restarts from address 0.
- Slot counter (2 bit):
  - The cycle after ce_pix has slot = 0; slot increments each cycle and saturates at 3.
  - ce_pix in any slot restarts the counter at 0; slots skipped by an early pulse are lost and no error is flagged.
- Pixel lookup (ce_pix at cycle T):
  - Latch idx = s ? cb : ca, and latch blank.
  - Video reads are issued only if blank = 0 and state != INIT:
    - T+1: ram_addr = {2'b00, idx} (R)
    - T+2: ram_addr = {2'b01, idx} (G)
    - T+3: ram_addr = {2'b10, idx} (B)
  - R and G data are captured into holding registers.
  - When B data arrives at T+4, r_out/g_out/b_out are loaded together; they are visible at T+5 and held until the next load.
  - If blank = 1 or state = INIT, RGB loads 0 at T+4 and slots 0-2 become CPU-eligible.
- CPU-eligible cycle: state = IDLE and (slot = 3, or the slot is freed by blank).
- State machine:
  - INIT:
    - Drive ram_we = 1, ram_wdata = 0, ram_addr = counter, one address per cycle from 0 to 767.
    - After writing 767 (768 cycles), go to IDLE and deassert init_busy.
    - cpu_req is ignored while in INIT; the request stays pending.
  - IDLE:
    - If cpu_req = 1 in a CPU-eligible cycle, the access issues that cycle.
    - Write: ram_addr = cpu_addr, ram_we = 1, ram_wdata = cpu_wdata.
    - Read: ram_addr = cpu_addr, ram_we = 0.
    - Then go to ACK.
  - ACK:
    - cpu_ack = 1 for one cycle; for a read, cpu_rdata = ram_rdata.
    - cpu_req is not sampled in this cycle.
    - Return to IDLE. The cycle after ACK is a video slot or a new CPU grant, as scheduled.
- Out-of-range cpu_addr (768-1023, i.e. ah = al = 1):
  - Writes are suppressed (ram_we stays 0), reads return 0.
  - Still acked with the same timing.
- Video and CPU never drive the RAM in the same cycle; video has priority in slots 0-2.
- cpu_rdata holds its value between acks.
- CPU worst-case latency with a 4-cycle pixel period: 4 cycles to grant plus 1 to ack.

Decomposition:
- Shared package palette_pkg:
  - PAL_R_BASE = 10'h000, PAL_G_BASE = 10'h100, PAL_B_BASE = 10'h200, PAL_DEPTH = 768.
  - Slot constants SLOT_R = 0, SLOT_G = 1, SLOT_B = 2, SLOT_CPU = 3.
  - State enum {INIT, IDLE, ACK}.
- RAM: palette_ram_sp (768x5, synchronous single port), instantiated alongside this block, not inside it.
- No internal sub-module; the slot counter and state machine stay in one module.

Test Plan:
- Reset, then wait: ram_we is high with addresses 0 to 767 over 768 cycles, init_busy falls on cycle 769, and a cpu_req held throughout is acked only afterwards.
- CPU write 0x1F to 0x005, 0x0A to 0x105, 0x03 to 0x205; then ce_pix with s = 0, ca = 0x05, blank = 0 at T: RGB = (1F, 0A, 03) at T+5.
- Same table with s = 1, cb = 0x05, ca = 0x06 (entry 6 never written): outputs (1F, 0A, 03). With s = 0 instead: (0, 0, 0).
- ce_pix every 4 cycles with cpu_req held for 3 writes: one grant per pixel, each in a slot-3 cycle; ram_we is never high in slots 0-2; each ack follows its grant by 1 cycle.
- blank = 1 with cpu_req held: back-to-back grants every 2 cycles (grant, ack); RGB = 0 at T+5.
- Read of 0x305: no ram_we, cpu_ack with cpu_rdata = 0. Reset asserted in the ACK cycle: no ack pulse, and init restarts at address 0.

Source files
------------

// File: rtl/palette_pkg.sv
// Shared constants and types for the palette RAM arbiter.
// Holds the RAM map, the slot numbering and the sequencer states.
package palette_pkg;

  localparam int AW        = 10;
  localparam int PAL_DEPTH = 768;

  localparam logic [AW-1:0] PAL_R_BASE = 10'h000;
  localparam logic [AW-1:0] PAL_G_BASE = 10'h100;
  localparam logic [AW-1:0] PAL_B_BASE = 10'h200;

  localparam logic [1:0] SLOT_R   = 2'd0;
  localparam logic [1:0] SLOT_G   = 2'd1;
  localparam logic [1:0] SLOT_B   = 2'd2;
  localparam logic [1:0] SLOT_CPU = 2'd3;

  typedef enum logic [1:0] {INIT, IDLE, ACK} state_t;

  // Base address of the colour plane read in a given video slot.
  function automatic logic [AW-1:0] slot_base(input logic [1:0] slot);
    case (slot)
      SLOT_R:  return PAL_R_BASE;
      SLOT_G:  return PAL_G_BASE;
      default: return PAL_B_BASE;
    endcase
  endfunction

endpackage

// File: rtl/palette_arbiter.sv
// Shares one single-port palette RAM between per-pixel RGB lookups and CPU
// accesses, and zero-fills the RAM after reset.
module palette_arbiter
  import palette_pkg::*;
#(
  parameter int PAL_DEPTH  = palette_pkg::PAL_DEPTH,
  parameter int DW         = 5,
  parameter int IW         = 8,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic          dclk,
  input  logic          reset,
  input  logic          ce_pix,
  input  logic          blank,
  input  logic          s,
  input  logic [IW-1:0] ca,
  input  logic [IW-1:0] cb,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic [DW-1:0] r_out,
  output logic [DW-1:0] g_out,
  output logic [DW-1:0] b_out,
  output logic          init_busy
);

  state_t        state, state_nx;
  logic [1:0]    slot;
  logic [IW-1:0] idx;
  logic          vid_en;
  logic [1:0]    rd_slot;
  logic          rd_vid;
  logic [DW-1:0] r_hold, g_hold;
  logic [AW-1:0] clr_addr;
  logic          acc_we_q, acc_oor_q;
  logic [DW-1:0] rdata_q, rd_live;
  logic          vid_busy, in_range, grant;

  // Video owns slots 0-2 only for a pixel that was visible when it was latched.
  assign vid_busy = vid_en && (slot != SLOT_CPU);
  assign in_range = (cpu_addr < AW'(PAL_DEPTH));
  assign rd_live  = acc_oor_q ? '0 : ram_rdata;
  assign cpu_rdata = (cpu_ack && !acc_we_q) ? rd_live : rdata_q;

  always_comb begin
    // NOTE: every signal written here gets a default first so no path infers a latch.
    state_nx  = state;
    grant     = 1'b0;
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    cpu_ack   = 1'b0;
    case (state)
      INIT:    if (clr_addr == AW'(PAL_DEPTH - 1)) state_nx = IDLE;
      IDLE:    if (cpu_req && !vid_busy) begin
                 grant    = 1'b1;
                 state_nx = ACK;
               end
      ACK:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // Strobes are masked while reset is held, so an ACK cut short never pulses.
    if (!reset) begin
      cpu_ack = (state == ACK);
      if (state == INIT) begin
        ram_addr = clr_addr;
        ram_we   = 1'b1;
      end else if (vid_busy) begin
        ram_addr = slot_base(slot) + AW'(idx);
      end else if (grant) begin
        ram_addr  = cpu_addr;
        ram_we    = cpu_we && in_range;
        ram_wdata = cpu_wdata;
      end
    end
  end

  always_ff @(posedge dclk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state     <= INIT_CLEAR ? INIT : IDLE;
      init_busy <= INIT_CLEAR;
      slot      <= SLOT_CPU;
      idx       <= '0;
      vid_en    <= 1'b0;
      rd_slot   <= SLOT_CPU;
      rd_vid    <= 1'b0;
      r_hold    <= '0;
      g_hold    <= '0;
      r_out     <= '0;
      g_out     <= '0;
      b_out     <= '0;
      clr_addr  <= '0;
      acc_we_q  <= 1'b0;
      acc_oor_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state     <= state_nx;
      init_busy <= (state_nx == INIT);
      if (state == INIT) clr_addr <= clr_addr + 1'b1;

      if (ce_pix) begin
        slot   <= SLOT_R;
        idx    <= s ? cb : ca;
        vid_en <= !blank && (state != INIT);
      end else if (slot != SLOT_CPU) begin
        slot <= slot + 2'd1;
      end

      // Read data trails its address by one cycle; tag it with the issuing slot.
      rd_slot <= slot;
      rd_vid  <= vid_en;
      if (rd_vid && rd_slot == SLOT_R) r_hold <= ram_rdata;
      if (rd_vid && rd_slot == SLOT_G) g_hold <= ram_rdata;
      if (rd_slot == SLOT_B) begin
        r_out <= rd_vid ? r_hold    : '0;
        g_out <= rd_vid ? g_hold    : '0;
        b_out <= rd_vid ? ram_rdata : '0;
      end

      if (grant) begin
        acc_we_q  <= cpu_we;
        acc_oor_q <= !in_range;
      end
      if (cpu_ack && !acc_we_q) rdata_q <= rd_live;
    end
  end

endmodule

// File: tb/tb_palette_arbiter.sv
// Self-checking bench for palette_arbiter with a behavioural palette RAM and
// a reference palette model updated from the CPU writes the bench issues.
module tb_palette_arbiter;

  logic       dclk = 1'b0;
  logic       reset, ce_pix, blank, s;
  logic [7:0] ca, cb;
  logic       cpu_req, cpu_we;
  logic [9:0] cpu_addr;
  logic [4:0] cpu_wdata;
  logic       cpu_ack;
  logic [4:0] cpu_rdata;
  logic [9:0] ram_addr;
  logic       ram_we;
  logic [4:0] ram_wdata;
  logic [4:0] ram_rdata;
  logic [4:0] r_out, g_out, b_out;
  logic       init_busy;

  int compared   = 0;
  int mismatched = 0;

  logic [4:0]  mem [1024];
  logic [4:0]  pal [768];
  logic [14:0] prev_rgb;
  int          k_a;

  palette_arbiter dut (
    .dclk(dclk), .reset(reset), .ce_pix(ce_pix), .blank(blank), .s(s),
    .ca(ca), .cb(cb), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
    .cpu_rdata(cpu_rdata), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .r_out(r_out),
    .g_out(g_out), .b_out(b_out), .init_busy(init_busy)
  );

  always #5 dclk = ~dclk;

  always @(posedge dclk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [14:0] exp_rgb(input int i);
    return {pal[i], pal[256 + i], pal[512 + i]};
  endfunction

  task automatic tick();
    @(posedge dclk);
    #1;
  endtask

  task automatic mid();
    @(negedge dclk);
  endtask

  task automatic cpu_xfer(input logic we, input logic [9:0] addr, input logic [4:0] wd,
                          output logic [4:0] rd, output bit ok);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    ok = 1'b0; rd = '0;
    for (int n = 0; n < 16 && !ok; n++) begin
      mid();
      if (cpu_ack === 1'b1) begin
        ok = 1'b1;
        rd = cpu_rdata;
      end
      tick();
    end
    cpu_req = 1'b0;
    if (ok && we && addr < 10'd768) pal[addr] = wd;
  endtask

  task automatic pixel(input logic sel, input logic [7:0] a, input logic [7:0] b,
                       input logic blk, output logic [14:0] t4, output logic [14:0] t5);
    ce_pix = 1'b1; s = sel; ca = a; cb = b; blank = blk;
    tick();
    ce_pix = 1'b0;
    repeat (3) tick();
    mid(); t4 = {r_out, g_out, b_out};
    tick();
    mid(); t5 = {r_out, g_out, b_out};
    tick();
  endtask

  task automatic test_reset();
    int first_bad;
    int ack_seen;
    reset = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h005; cpu_wdata = 5'h1F;
    repeat (3) tick();
    mid();
    compared++;
    if ({cpu_ack, cpu_rdata, ram_we, ram_addr, ram_wdata, r_out, g_out, b_out} !== '0 ||
        init_busy !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_state: ack=%b rdata=%h we=%b addr=%h rgb=%h/%h/%h busy=%b, required all 0 and busy=1",
               cpu_ack, cpu_rdata, ram_we, ram_addr, r_out, g_out, b_out, init_busy);
    end
    tick();
    reset = 1'b0;
    first_bad = -1; ack_seen = 0;
    for (int i = 0; i < 768; i++) begin
      mid();
      if (first_bad < 0 && (ram_we !== 1'b1 || ram_addr !== 10'(i) ||
                            ram_wdata !== 5'h00 || init_busy !== 1'b1))
        first_bad = i;
      if (cpu_ack === 1'b1) ack_seen++;
      tick();
    end
    compared++;
    if (first_bad >= 0) begin
      mismatched++;
      $display("FAIL init_sweep: first wrong clear cycle %0d (we=%b addr=%h), required we=1 addr=%h",
               first_bad, ram_we, ram_addr, first_bad);
    end
    compared++;
    if (ack_seen != 0) begin
      mismatched++;
      $display("FAIL ack_during_init: %0d acks, required 0", ack_seen);
    end
    mid();
    compared++;
    if (init_busy !== 1'b0) begin
      mismatched++;
      $display("FAIL init_busy_fall: cycle 769 init_busy=%b, required 0", init_busy);
    end
    compared++;
    if (ram_we !== 1'b1 || ram_addr !== 10'h005 || ram_wdata !== 5'h1F) begin
      mismatched++;
      $display("FAIL held_req_grant: we=%b addr=%h wd=%h, required 1/005/1F", ram_we, ram_addr, ram_wdata);
    end
    tick();
    mid();
    compared++;
    if (cpu_ack !== 1'b1) begin
      mismatched++;
      $display("FAIL held_req_ack: ack=%b, required 1", cpu_ack);
    end
    tick();
    cpu_req = 1'b0;
    pal[5] = 5'h1F;
    prev_rgb = '0;
  endtask

  task automatic test_lookup();
    logic [4:0]  rd;
    bit          ok;
    logic [14:0] t4, t5;
    logic [7:0]  pick;
    int          okc;
    okc = 0;
    cpu_xfer(1'b1, 10'h105, 5'h0A, rd, ok); okc += int'(ok);
    cpu_xfer(1'b1, 10'h205, 5'h03, rd, ok); okc += int'(ok);
    k_a = $urandom_range(16, 127);
    for (int p = 0; p < 3; p++) begin
      cpu_xfer(1'b1, 10'(p * 256 + k_a), 5'($urandom_range(1, 31)), rd, ok);
      okc += int'(ok);
    end
    compared++;
    if (okc != 5) begin
      mismatched++;
      $display("FAIL setup_writes: %0d acked, required 5", okc);
    end

    pixel(1'b0, 8'h05, 8'($urandom), 1'b0, t4, t5);
    compared++;
    if (t4 !== prev_rgb) begin
      mismatched++;
      $display("FAIL rgb_not_before_t5: got %h, required %h", t4, prev_rgb);
    end
    compared++;
    if (t5 !== 15'({5'h1F, 5'h0A, 5'h03})) begin
      mismatched++;
      $display("FAIL rgb_sel_a: got %h, required %h", t5, {5'h1F, 5'h0A, 5'h03});
    end
    prev_rgb = t5;

    pixel(1'b1, 8'h06, 8'h05, 1'b0, t4, t5);
    compared++;
    if (t5 !== exp_rgb(5)) begin
      mismatched++;
      $display("FAIL rgb_sel_b: got %h, required %h", t5, exp_rgb(5));
    end

    pixel(1'b0, 8'h06, 8'h05, 1'b0, t4, t5);
    compared++;
    if (t5 !== 15'h0000) begin
      mismatched++;
      $display("FAIL rgb_unwritten: got %h, required 0", t5);
    end

    for (int n = 0; n < 4; n++) begin
      logic sel;
      logic [7:0] other;
      sel   = 1'($urandom);
      pick  = ($urandom_range(0, 1) == 0) ? 8'(k_a) : 8'h05;
      other = 8'($urandom);
      pixel(sel, sel ? other : pick, sel ? pick : other, 1'b0, t4, t5);
      compared++;
      if (t5 !== exp_rgb(int'(pick))) begin
        mismatched++;
        $display("FAIL rgb_random: idx=%h got %h, required %h", pick, t5, exp_rgb(int'(pick)));
      end
    end
    pixel(1'b0, 8'h05, 8'h00, 1'b0, t4, t5);
    prev_rgb = exp_rgb(5);
  endtask

  task automatic test_interleave();
    logic [9:0]  wa [3];
    logic [4:0]  wd [3];
    logic [7:0]  pix [3];
    int          head, k_b;
    bit          ack_due;
    logic [14:0] t4, t5;
    k_b = $urandom_range(128, 255);
    for (int p = 0; p < 3; p++) begin
      wa[p]  = 10'(p * 256 + k_b);
      wd[p]  = 5'($urandom_range(1, 31));
      pix[p] = ($urandom_range(0, 1) == 0) ? 8'(k_a) : 8'h05;
    end
    head = 0; ack_due = 1'b0;
    for (int c = 0; c < 16; c++) begin
      bit vid, gnt;
      ce_pix = (c % 4 == 0) && (c < 12);
      s = 1'b0; blank = 1'b0; ca = pix[(c < 12) ? c / 4 : 2];
      cpu_req = (head < 3); cpu_we = 1'b1;
      cpu_addr = wa[(head < 3) ? head : 2]; cpu_wdata = wd[(head < 3) ? head : 2];
      vid = (c >= 1) && (c <= 11) && (c % 4 != 0);
      gnt = (c % 4 == 0) && (head < 3);
      mid();
      compared++;
      if (vid) begin
        logic [9:0] ea;
        ea = 10'(((c - 1) % 4) * 256 + int'(pix[(c - 1) / 4]));
        if (ram_we !== 1'b0 || ram_addr !== ea) begin
          mismatched++;
          $display("FAIL video_slot c%0d: we=%b addr=%h, required 0/%h", c, ram_we, ram_addr, ea);
        end
      end else if (gnt) begin
        if (ram_we !== 1'b1 || ram_addr !== wa[head] || ram_wdata !== wd[head]) begin
          mismatched++;
          $display("FAIL slot3_grant c%0d: we=%b addr=%h, required 1/%h", c, ram_we, ram_addr, wa[head]);
        end
      end else if (ram_we !== 1'b0) begin
        mismatched++;
        $display("FAIL stray_write c%0d: we=%b, required 0", c, ram_we);
      end
      compared++;
      if (cpu_ack !== ack_due) begin
        mismatched++;
        $display("FAIL interleave_ack c%0d: ack=%b, required %b", c, cpu_ack, ack_due);
      end
      if (c == 5 || c == 9 || c == 13) begin
        compared++;
        if ({r_out, g_out, b_out} !== exp_rgb(int'(pix[(c - 5) / 4]))) begin
          mismatched++;
          $display("FAIL interleave_rgb c%0d: got %h, required %h", c, {r_out, g_out, b_out},
                   exp_rgb(int'(pix[(c - 5) / 4])));
        end
      end
      if (ack_due) head++;
      ack_due = gnt;
      tick();
    end
    ce_pix = 1'b0; cpu_req = 1'b0;
    for (int p = 0; p < 3; p++) pal[wa[p]] = wd[p];
    pixel(1'b0, 8'(k_b), 8'h00, 1'b0, t4, t5);
    compared++;
    if (t5 !== exp_rgb(k_b)) begin
      mismatched++;
      $display("FAIL interleave_readback: got %h, required %h", t5, exp_rgb(k_b));
    end
    pixel(1'b0, 8'h05, 8'h00, 1'b0, t4, t5);
    prev_rgb = exp_rgb(5);
  endtask

  task automatic test_blank();
    logic [9:0] wa [3];
    logic [4:0] wd [3];
    int         head;
    for (int p = 0; p < 3; p++) begin
      wa[p] = 10'($urandom_range(300, 767));
      wd[p] = 5'($urandom);
    end
    head = 0;
    for (int c = 0; c < 8; c++) begin
      bit gnt, ack_e;
      ce_pix = (c == 0); blank = 1'b1; s = 1'b0; ca = 8'h05;
      cpu_req = (head < 3); cpu_we = 1'b1;
      cpu_addr = wa[(head < 3) ? head : 2]; cpu_wdata = wd[(head < 3) ? head : 2];
      gnt   = (c % 2 == 0) && (c <= 4);
      ack_e = (c % 2 == 1) && (c <= 5);
      mid();
      compared++;
      if (gnt ? (ram_we !== 1'b1 || ram_addr !== wa[head]) : (ram_we !== 1'b0)) begin
        mismatched++;
        $display("FAIL blank_grant c%0d: we=%b addr=%h, required grant=%b", c, ram_we, ram_addr, gnt);
      end
      compared++;
      if (cpu_ack !== ack_e) begin
        mismatched++;
        $display("FAIL blank_ack c%0d: ack=%b, required %b", c, cpu_ack, ack_e);
      end
      if (c == 4 || c == 5) begin
        compared++;
        if ({r_out, g_out, b_out} !== ((c == 4) ? prev_rgb : 15'h0000)) begin
          mismatched++;
          $display("FAIL blank_rgb c%0d: got %h, required %h", c, {r_out, g_out, b_out},
                   (c == 4) ? prev_rgb : 15'h0000);
        end
      end
      if (ack_e) begin
        pal[wa[head]] = wd[head];
        head++;
      end
      tick();
    end
    ce_pix = 1'b0; blank = 1'b0; cpu_req = 1'b0;
    prev_rgb = '0;
  endtask

  task automatic test_read();
    logic [4:0] rd;
    bit         ok;
    logic [9:0] a;
    for (int n = 0; n < 6; n++) begin
      a = (n == 0) ? 10'h005 : 10'($urandom_range(0, 767));
      cpu_xfer(1'b0, a, 5'h00, rd, ok);
      compared++;
      if (!ok || rd !== pal[a]) begin
        mismatched++;
        $display("FAIL cpu_read %h: acked=%b data=%h, required %h", a, ok, rd, pal[a]);
      end
      if (n == 0) begin
        mid();
        compared++;
        if (cpu_rdata !== 5'h1F) begin
          mismatched++;
          $display("FAIL rdata_hold: got %h, required 1F", cpu_rdata);
        end
        tick();
      end
    end
  endtask

  task automatic test_oor();
    bit we_seen;
    int ack_at;
    logic [4:0] rd;
    for (int w = 0; w < 2; w++) begin
      cpu_req = 1'b1; cpu_we = 1'(w); cpu_addr = (w == 0) ? 10'h305 : 10'h3AA;
      cpu_wdata = 5'h1E;
      we_seen = 1'b0; ack_at = -1; rd = 5'h1F;
      for (int n = 0; n < 4; n++) begin
        mid();
        if (ram_we === 1'b1) we_seen = 1'b1;
        if (cpu_ack === 1'b1 && ack_at < 0) begin
          ack_at = n;
          rd = cpu_rdata;
        end
        if (n == 1) cpu_req = 1'b0;
        tick();
      end
      cpu_req = 1'b0;
      compared++;
      if (we_seen || ack_at != 1) begin
        mismatched++;
        $display("FAIL oor_access w%0d: we_seen=%b ack_cycle=%0d, required 0 and 1", w, we_seen, ack_at);
      end
      compared++;
      if (w == 0 ? (rd !== 5'h00) : (mem[10'h3AA] !== 5'h0B)) begin
        mismatched++;
        $display("FAIL oor_data w%0d: rdata=%h mem=%h, required rdata 0 / mem 0B", w, rd, mem[10'h3AA]);
      end
    end
  endtask

  task automatic test_reset_in_ack();
    int first_bad;
    int waited;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h005;
    mid();
    compared++;
    if (ram_addr !== 10'h005 || ram_we !== 1'b0) begin
      mismatched++;
      $display("FAIL abort_grant: addr=%h we=%b, required 005/0", ram_addr, ram_we);
    end
    tick();
    reset = 1'b1; cpu_req = 1'b0;
    mid();
    compared++;
    if (cpu_ack !== 1'b0) begin
      mismatched++;
      $display("FAIL abort_no_ack: ack=%b, required 0", cpu_ack);
    end
    tick();
    reset = 1'b0;
    first_bad = -1;
    for (int i = 0; i < 4; i++) begin
      mid();
      if (first_bad < 0 && (ram_we !== 1'b1 || ram_addr !== 10'(i) ||
                            init_busy !== 1'b1 || cpu_ack !== 1'b0))
        first_bad = i;
      tick();
    end
    compared++;
    if (first_bad >= 0) begin
      mismatched++;
      $display("FAIL init_restart: cycle %0d addr=%h we=%b, required we=1 addr=%h", first_bad, ram_addr,
               ram_we, first_bad);
    end
    waited = 0;
    while (init_busy === 1'b1 && waited < 800) begin
      tick();
      waited++;
    end
    compared++;
    if (init_busy !== 1'b0 || waited != 764) begin
      mismatched++;
      $display("FAIL init_restart_len: waited %0d, required 764", waited);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 5'($urandom);
    mem[10'h305] = 5'h15;
    mem[10'h3AA] = 5'h0B;
    for (int i = 0; i < 768; i++) pal[i] = 5'h00;
    ram_rdata = '0;
    ce_pix = 1'b0; blank = 1'b0; s = 1'b0; ca = '0; cb = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    reset = 1'b1;
    prev_rgb = '0;
    k_a = 16;
    test_reset();
    test_lookup();
    test_interleave();
    test_blank();
    test_read();
    test_oor();
    test_reset_in_ack();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
